sumador_fixed_pipe: RTL and testbench
=====================================

# sumador_fixed_pipe

Pipelined, fully parametrised signed fixed-point adder with runtime-selectable quantisation: wrap/saturate and truncate/round-half-up, chosen per sample. It generalises the team's combinational fixed-point adder into a two-stage registered datapath with valid tracking, overflow reporting and an optional saturation-event counter. It sits between filter/mixer stages in the baseband chain wherever two differently formatted signals are summed and requantised.

## Interface
- NBA, 16, total bits of input A, format S(NBA,NBFA)
- NBFA, 14, fractional bits of A
- NBB, 12, total bits of input B, format S(NBB,NBFB)
- NBFB, 11, fractional bits of B
- NBS, 11, total bits of output, format S(NBS,NBFS)
- NBFS, 10, fractional bits of output; NBFS ≤ max(NBFA,NBFB), NBS−NBFS ≤ max(NBA−NBFA,NBB−NBFB)+1
- NBCNT, 16, width of saturation-event counter
- clk  in  1  clock, all registers rising-edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  operands and mode valid this cycle
- i_a  in  NBA  signed operand A
- i_b  in  NBB  signed operand B
- i_mode  in  2  bit0: 1=round half-up, 0=truncate; bit1: 1=saturate, 0=wrap
- i_clr_ovf  in  1  clears sticky flag and counter
- o_valid  out  1  o_sum valid
- o_full  out  NBF+1  unquantised full-precision sum, S(NI+NF+1,NF), NF=max(NBFA,NBFB), NI=max integer bits
- o_sum  out  NBS  quantised result
- o_ovf  out  1  current o_sum overflowed (wrapped or clipped)
- o_ovf_sticky  out  1  any overflow since reset/clear
- o_sat_cnt  out  NBCNT  overflow event count (macro-dependent)

## Operation
- Stage 1: sign-extend each operand to NI integer bits, zero-pad fraction to NF bits, add with one guard bit → full sum; register full sum, mode, valid.
- Stage 2: quantise. Drop D=NF−NBFS LSBs. Round: add 1 at weight 2^(D−1) into a one-bit-wider word, then floor; D=0 → round is a no-op. Truncate: floor (toward −∞).
- Overflow: discarded MSBs above output sign bit not all equal to that sign bit; evaluated after rounding.
- Wrap: keep low NBS bits. Saturate: positive → {0,1…1}, negative → {1,0…0}.
- o_ovf asserted with the sample in both modes; sticky set on any valid overflowed sample.
- Data registers load only when their stage's valid is 1; otherwise hold.
- i_clr_ovf: clears sticky and counter next edge; simultaneous overflow in same cycle wins (flag set, counter = 1).
- Counter increments per valid overflowed sample, holds at all-ones.

## Timing
- Latency 2: sample presented at edge n → o_valid, o_sum, o_full at edge n+2. Throughput one sample/cycle, no backpressure.
- o_full from stage 1 is re-registered so it aligns with o_sum.
- Reset: all outputs and internal registers 0 immediately; in-flight samples discarded; o_valid low until two edges after first post-reset i_valid.
- i_mode sampled with operands; changing mode every cycle is legal.

## Configuration
- SUMADOR_FIXED_SAT_CNT_EN defined: counter implemented as above.
- Undefined: no counter register; o_sat_cnt tied to 0; port kept.

## Structure
- Package fixed_pkg: mode bit index constants (MODE_RND, MODE_SAT), max/width helper functions for NI, NF, full width.
- Sub-module fixed_quantizer: combinational round/overflow/saturate of stage 2, parametrised by input and output formats; reused by other requantising blocks.

## Test plan
- Defaults, i_a=16'h6000 (1.5), i_b=12'h400 (0.5), mode=2'b10 → o_full=17'h08000, o_sum=11'h3FF, o_ovf=1; mode=2'b00 → o_sum=11'h000, o_ovf=1.
- i_a=16'h8000 (−2.0), i_b=12'hC00 (−0.5): saturate → 11'h400; wrap → 11'h600; o_ovf=1 both.
- i_a=16'h0018, i_b=0: truncate → 11'h001, round → 11'h002; i_a=16'hFFE8: truncate → 11'h7FE, round → 11'h7FF; o_ovf=0.
- Back-to-back valids with alternating modes for 20 cycles → outputs match model exactly two cycles later, o_valid pattern delayed by 2.
- Three overflows then i_clr_ovf coincident with a fourth → sticky stays 1, counter=1 (with macro), 0 without.
- Assert i_rst_n low while two samples in flight → o_valid, o_sum, o_ovf_sticky 0 immediately; no stale output after release.

Source files
------------

// File: rtl/fixed_pkg.sv
// fixed_pkg: shared definitions for the signed fixed-point datapath blocks.
//   MODE_RND / MODE_SAT : bit positions inside the 2-bit quantisation mode word
//   max_i               : integer maximum
//   frac_w / int_w      : aligned fractional / integer bit counts of two formats
//   full_w              : width of the full-precision sum (int + frac + guard)
package fixed_pkg;

  localparam int MODE_RND = 0;
  localparam int MODE_SAT = 1;

  function automatic int max_i(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic int frac_w(input int nbfa, input int nbfb);
    return max_i(nbfa, nbfb);
  endfunction

  function automatic int int_w(input int nba, input int nbfa,
                               input int nbb, input int nbfb);
    return max_i(nba - nbfa, nbb - nbfb);
  endfunction

  function automatic int full_w(input int nba, input int nbfa,
                                input int nbb, input int nbfb);
    return int_w(nba, nbfa, nbb, nbfb) + frac_w(nbfa, nbfb) + 1;
  endfunction

endpackage

// File: rtl/fixed_quantizer.sv
// fixed_quantizer: combinational requantiser S(NBI,NBFI) -> S(NBO,NBFO).
//   in_i  : full-precision signed input
//   rnd_i : 1 = round half-up, 0 = truncate (floor)
//   sat_i : 1 = saturate on overflow, 0 = wrap
//   out_o : quantised result
//   ovf_o : result overflowed the output format (after rounding)
// Requires NBFO <= NBFI and NBO - NBFO <= NBI - NBFI + 1.
module fixed_quantizer #(
  parameter int NBI  = 17,
  parameter int NBFI = 14,
  parameter int NBO  = 11,
  parameter int NBFO = 10
) (
  input  logic [NBI-1:0] in_i,
  input  logic           rnd_i,
  input  logic           sat_i,
  output logic [NBO-1:0] out_o,
  output logic           ovf_o
);

  localparam int D  = NBFI - NBFO;
  localparam int RW = NBI + 1;
  localparam int DH = (D > 0) ? D - 1 : 0;
  localparam logic [RW-1:0] HALF = (D > 0) ? (RW'(1) << DH) : '0;

  logic [RW-1:0]  ext;
  logic [RW-1:0]  rnd;
  logic [RW-1:0]  sh;
  logic [RW-NBO:0] upper;
  logic [NBO-1:0] satv;

  always_comb begin
    // One extra bit so the rounding increment can never overflow the word.
    ext   = {in_i[NBI-1], in_i};
    rnd   = ext + (rnd_i ? HALF : '0);
    // Arithmetic shift keeps the full word width, so every bit above the
    // output sign position is available for the overflow test.
    sh    = $signed(rnd) >>> D;
    upper = sh[RW-1:NBO-1];
    ovf_o = (|upper) && !(&upper);
    satv  = sh[RW-1] ? {1'b1, {(NBO-1){1'b0}}} : {1'b0, {(NBO-1){1'b1}}};
    out_o = (ovf_o && sat_i) ? satv : sh[NBO-1:0];
  end

endmodule

// File: rtl/sumador_fixed_pipe.sv
// sumador_fixed_pipe: two-stage pipelined signed fixed-point adder with
// per-sample quantisation mode (round/truncate, saturate/wrap).
//   clk, i_rst_n    : rising-edge clock, asynchronous active-low reset
//   i_valid, i_a, i_b, i_mode : sample input; i_mode[0]=round, i_mode[1]=saturate
//   i_clr_ovf       : clears sticky overflow flag and event counter
//   o_valid, o_full, o_sum, o_ovf : result, latency 2
//   o_ovf_sticky    : any overflow since reset/clear
//   o_sat_cnt       : overflow event counter (saturating)
// Macro SUMADOR_FIXED_SAT_CNT_EN: when defined the counter is built;
// otherwise o_sat_cnt is tied to zero.
module sumador_fixed_pipe
  import fixed_pkg::*;
#(
  parameter int NBA   = 16,
  parameter int NBFA  = 14,
  parameter int NBB   = 12,
  parameter int NBFB  = 11,
  parameter int NBS   = 11,
  parameter int NBFS  = 10,
  parameter int NBCNT = 16
) (
  input  logic                                  clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_valid,
  input  logic [NBA-1:0]                        i_a,
  input  logic [NBB-1:0]                        i_b,
  input  logic [1:0]                            i_mode,
  input  logic                                  i_clr_ovf,
  output logic                                  o_valid,
  output logic [full_w(NBA,NBFA,NBB,NBFB)-1:0]  o_full,
  output logic [NBS-1:0]                        o_sum,
  output logic                                  o_ovf,
  output logic                                  o_ovf_sticky,
  output logic [NBCNT-1:0]                      o_sat_cnt
);

  localparam int NF = frac_w(NBFA, NBFB);
  localparam int NW = full_w(NBA, NBFA, NBB, NBFB);

  logic [NW-1:0]  a_al, b_al, full_d;
  logic           v1_q;
  logic [NW-1:0]  full1_q;
  logic [1:0]     mode1_q;
  logic           v2_q;
  logic [NW-1:0]  full2_q;
  logic [NBS-1:0] sum_q, q_sum;
  logic           ovf_q, q_ovf;
  logic           sticky_q, sticky_d;
  logic           ovf_evt;

  // Stage 1: align both operands to NF fractional bits inside the guarded width.
  always_comb begin
    a_al   = {{(NW-NBA){i_a[NBA-1]}}, i_a} << (NF - NBFA);
    b_al   = {{(NW-NBB){i_b[NBB-1]}}, i_b} << (NF - NBFB);
    full_d = a_al + b_al;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q    <= 1'b0;
      full1_q <= '0;
      mode1_q <= '0;
    end else begin
      v1_q <= i_valid;
      if (i_valid) begin
        full1_q <= full_d;
        mode1_q <= i_mode;
      end
    end
  end

  fixed_quantizer #(
    .NBI  (NW),
    .NBFI (NF),
    .NBO  (NBS),
    .NBFO (NBFS)
  ) u_quant (
    .in_i  (full1_q),
    .rnd_i (mode1_q[MODE_RND]),
    .sat_i (mode1_q[MODE_SAT]),
    .out_o (q_sum),
    .ovf_o (q_ovf)
  );

  // An overflow event arriving together with a clear takes priority.
  always_comb begin
    ovf_evt  = v1_q & q_ovf;
    sticky_d = sticky_q;
    if (ovf_evt)        sticky_d = 1'b1;
    else if (i_clr_ovf) sticky_d = 1'b0;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v2_q     <= 1'b0;
      full2_q  <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      v2_q     <= v1_q;
      sticky_q <= sticky_d;
      if (v1_q) begin
        full2_q <= full1_q;
        sum_q   <= q_sum;
        ovf_q   <= q_ovf;
      end
    end
  end

`ifdef SUMADOR_FIXED_SAT_CNT_EN
  logic [NBCNT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr_ovf)                  cnt_d = ovf_evt ? NBCNT'(1) : '0;
    else if (ovf_evt && !(&cnt_q))  cnt_d = cnt_q + NBCNT'(1);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_sat_cnt = cnt_q;
`else
  assign o_sat_cnt = '0;
`endif

  assign o_valid      = v2_q;
  assign o_full       = full2_q;
  assign o_sum        = sum_q;
  assign o_ovf        = ovf_q;
  assign o_ovf_sticky = sticky_q;

endmodule

// File: tb/tb_sumador_fixed_pipe.sv
// Directed bench for sumador_fixed_pipe at default parameters.
module tb_sumador_fixed_pipe;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_a = '0;
  logic [11:0] i_b = '0;
  logic [1:0]  i_mode = '0;
  logic        i_clr_ovf = 1'b0;
  logic        o_valid;
  logic [16:0] o_full;
  logic [10:0] o_sum;
  logic        o_ovf;
  logic        o_ovf_sticky;
  logic [15:0] o_sat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sumador_fixed_pipe dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_mode       (i_mode),
    .i_clr_ovf    (i_clr_ovf),
    .o_valid      (o_valid),
    .o_full       (o_full),
    .o_sum        (o_sum),
    .o_ovf        (o_ovf),
    .o_ovf_sticky (o_ovf_sticky),
    .o_sat_cnt    (o_sat_cnt)
  );

`ifdef SUMADOR_FIXED_SAT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // Directed quantisation vectors: a, b, mode, full, sum, ovf
  logic [15:0] qa [12] = '{16'h6000, 16'h6000, 16'h8000, 16'h8000, 16'h0018, 16'h0018,
                           16'hFFE8, 16'hFFE8, 16'h3FF8, 16'h3FF8, 16'h3FF8, 16'hC000};
  logic [11:0] qb [12] = '{12'h400, 12'h400, 12'hC00, 12'hC00, 12'h000, 12'h000,
                           12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
  logic [1:0]  qm [12] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01,
                           2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b10};
  logic [16:0] qf [12] = '{17'h08000, 17'h08000, 17'h16000, 17'h16000, 17'h00018, 17'h00018,
                           17'h1FFE8, 17'h1FFE8, 17'h03FF8, 17'h03FF8, 17'h03FF8, 17'h1C000};
  logic [10:0] qs [12] = '{11'h3FF, 11'h000, 11'h400, 11'h600, 11'h001, 11'h002,
                           11'h7FE, 11'h7FF, 11'h3FF, 11'h400, 11'h3FF, 11'h400};
  logic        qo [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Integer reference: S(16,14) + S(12,11) -> S(11,10), D = 4.
  function automatic void model(input logic [15:0] a, input logic [11:0] b,
                                input logic [1:0] m, output logic [16:0] f,
                                output logic [10:0] s, output logic o);
    int full, q;
    full = int'($signed(a)) + int'($signed(b)) * 8;
    f    = 17'(full);
    q    = (full + (m[0] ? 8 : 0)) >>> 4;
    o    = (q > 1023) || (q < -1024);
    if (o && m[1]) q = (q > 0) ? 1023 : -1024;
    s    = 11'(q);
  endfunction

  task automatic test_reset();
    i_rst_n = 1'b0;
    #3;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_full !== 17'h0) begin errors++; $display("FAIL reset_full got %h want 0", o_full); end
    checks++; if (o_sum !== 11'h0) begin errors++; $display("FAIL reset_sum got %h want 0", o_sum); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", o_ovf); end
    checks++; if (o_ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", o_ovf_sticky); end
    checks++; if (o_sat_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", o_sat_cnt); end
    @(negedge clk);
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_quant();
    for (int i = 0; i < 12; i++) begin
      i_valid = 1'b1; i_a = qa[i]; i_b = qb[i]; i_mode = qm[i];
      step();
      i_valid = 1'b0;
      step();
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL quant%0d_valid got %b want 1", i, o_valid); end
      checks++; if (o_full !== qf[i]) begin errors++; $display("FAIL quant%0d_full got %h want %h", i, o_full, qf[i]); end
      checks++; if (o_sum !== qs[i]) begin errors++; $display("FAIL quant%0d_sum got %h want %h", i, o_sum, qs[i]); end
      checks++; if (o_ovf !== qo[i]) begin errors++; $display("FAIL quant%0d_ovf got %b want %b", i, o_ovf, qo[i]); end
    end
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL quant_idle_valid got %b want 0", o_valid); end
  endtask

  task automatic test_back_to_back();
    logic        ev [20];
    logic [16:0] ef [20];
    logic [10:0] es [20];
    logic        eo [20];
    for (int c = 0; c <= 20; c++) begin
      if (c < 20) begin
        i_valid = (c % 7) != 3;
        i_a     = 16'(c * 16'h1357 + 16'h0A3C);
        i_b     = 12'(c * 12'h2B9) ^ 12'h5A5;
        i_mode  = 2'(c);
        ev[c]   = i_valid;
        model(i_a, i_b, i_mode, ef[c], es[c], eo[c]);
      end else begin
        i_valid = 1'b0;
      end
      step();
      if (c >= 1) begin
        checks++; if (o_valid !== ev[c-1]) begin errors++; $display("FAIL b2b%0d_valid got %b want %b", c-1, o_valid, ev[c-1]); end
        if (ev[c-1]) begin
          checks++; if (o_full !== ef[c-1]) begin errors++; $display("FAIL b2b%0d_full got %h want %h", c-1, o_full, ef[c-1]); end
          checks++; if (o_sum !== es[c-1]) begin errors++; $display("FAIL b2b%0d_sum got %h want %h", c-1, o_sum, es[c-1]); end
          checks++; if (o_ovf !== eo[c-1]) begin errors++; $display("FAIL b2b%0d_ovf got %b want %b", c-1, o_ovf, eo[c-1]); end
        end
      end
    end
    step();
  endtask

  task automatic test_sticky_clear();
    i_clr_ovf = 1'b1;
    step();
    i_clr_ovf = 1'b0;
    checks++; if (o_ovf_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky got %b want 0", o_ovf_sticky); end
    checks++; if (o_sat_cnt !== 16'h0) begin errors++; $display("FAIL clr_cnt got %h want 0", o_sat_cnt); end
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_a = 16'h6000; i_b = 12'h400; i_mode = 2'b10;
      step();
    end
    i_valid = 1'b0;
    checks++; if (o_ovf_sticky !== 1'b1) begin errors++; $display("FAIL three_sticky got %b want 1", o_ovf_sticky); end
    checks++; if (o_sat_cnt !== (CNT_EN ? 16'd3 : 16'd0)) begin errors++; $display("FAIL three_cnt got %0d want %0d", o_sat_cnt, CNT_EN ? 3 : 0); end
    // Fourth overflow is in stage 2 during this cycle, coinciding with the clear.
    i_clr_ovf = 1'b1;
    step();
    checks++; if (o_ovf_sticky !== 1'b1) begin errors++; $display("FAIL coinc_sticky got %b want 1", o_ovf_sticky); end
    checks++; if (o_sat_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL coinc_cnt got %0d want %0d", o_sat_cnt, CNT_EN ? 1 : 0); end
    step();
    i_clr_ovf = 1'b0;
    checks++; if (o_ovf_sticky !== 1'b0) begin errors++; $display("FAIL clr2_sticky got %b want 0", o_ovf_sticky); end
    checks++; if (o_sat_cnt !== 16'h0) begin errors++; $display("FAIL clr2_cnt got %h want 0", o_sat_cnt); end
    step();
  endtask

  task automatic test_reset_inflight();
    i_valid = 1'b1; i_a = 16'h6000; i_b = 12'h400; i_mode = 2'b10;
    step();
    step();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got %b want 1", o_valid); end
    checks++; if (o_ovf_sticky !== 1'b1) begin errors++; $display("FAIL pre_rst_sticky got %b want 1", o_ovf_sticky); end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", o_valid); end
    checks++; if (o_sum !== 11'h0) begin errors++; $display("FAIL rst_sum got %h want 0", o_sum); end
    checks++; if (o_full !== 17'h0) begin errors++; $display("FAIL rst_full got %h want 0", o_full); end
    checks++; if (o_ovf_sticky !== 1'b0) begin errors++; $display("FAIL rst_sticky got %b want 0", o_ovf_sticky); end
    i_valid = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stale%0d_valid got %b want 0", k, o_valid); end
      checks++; if (o_sum !== 11'h0) begin errors++; $display("FAIL stale%0d_sum got %h want 0", k, o_sum); end
    end
    i_valid = 1'b1; i_a = 16'h0018; i_b = 12'h000; i_mode = 2'b01;
    step();
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL post_rst_early_valid got %b want 0", o_valid); end
    step();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got %b want 1", o_valid); end
    checks++; if (o_sum !== 11'h002) begin errors++; $display("FAIL post_rst_sum got %h want 002", o_sum); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_quant();
    test_back_to_back();
    test_sticky_clear();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
